// File: rtl/counter_monitor_if.sv
// Output bundle of the SAR bring-up sequencer: phase strobes plus the
// differential DAC bit lines (d1 = MSB).
interface counter_monitor_if;
  logic sample;
  logic comp_en;
  logic d1, d2, d3, d4, d5, d6;
  logic d1b, d2b, d3b, d4b, d5b, d6b;

  modport master (
    output sample, comp_en,
    output d1, d2, d3, d4, d5, d6,
    output d1b, d2b, d3b, d4b, d5b, d6b
  );

  modport slave (
    input sample, comp_en,
    input d1, d2, d3, d4, d5, d6,
    input d1b, d2b, d3b, d4b, d5b, d6b
  );
endinterface

// File: rtl/counter_monitor.sv
// Free-running SAR-style frame sequencer for bring-up of a 6-bit cap-DAC slice.
// Each frame: SAMPLE_CYCLES of sample, six bit-trial steps revealing the test
// code MSB first, one hold cycle; the code then advances by CODE_STEP mod 64.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | post-reset; leaves on the first clock edge with rst_n high
//  SAMPLE | sample=1, bit lines cleared; down-counter times the phase
//  TRIAL  | comp_en=1; step k reveals d(k+1) = code[5-k]
//  HOLD   | full code on the bit lines for one cycle, then code advances
module counter_monitor #(
  parameter int SAMPLE_CYCLES = 2,
  parameter int CODE_STEP     = 1,
  parameter int CODE_INIT     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  counter_monitor_if.master mon_bus
);

  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, HOLD} state_t;

  localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_CYCLES - 1);
  localparam logic [5:0] STEP_V      = 6'(CODE_STEP);
  localparam logic [5:0] INIT_V      = 6'(CODE_INIT);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_step;
  logic [5:0] r_code;
  logic [5:0] r_d;
  logic       r_sample;
  logic       r_comp_en;

  // Bit position revealed when the trial step advances from r_step to r_step+1.
  logic [2:0] w_idx;
  assign w_idx = 3'd4 - r_step;

  // Frame sequencer: next state and registered outputs in one place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_step    <= 3'd0;
      r_code    <= INIT_V;
      r_d       <= 6'd0;
      r_sample  <= 1'b0;
      r_comp_en <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state  <= SAMPLE;
          r_sample <= 1'b1;
          r_cnt    <= SAMPLE_LAST;
          r_d      <= 6'd0;
        end
        SAMPLE: begin
          if (r_cnt == 4'd0) begin
            r_state   <= TRIAL;
            r_sample  <= 1'b0;
            r_comp_en <= 1'b1;
            r_step    <= 3'd0;
            r_d       <= {r_code[5], 5'd0};
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        TRIAL: begin
          if (r_step == 3'd5) begin
            r_state   <= HOLD;
            r_comp_en <= 1'b0;
          end else begin
            r_step     <= r_step + 3'd1;
            r_d[w_idx] <= r_code[w_idx];
          end
        end
        HOLD: begin
          r_state  <= SAMPLE;
          r_sample <= 1'b1;
          r_cnt    <= SAMPLE_LAST;
          r_d      <= 6'd0;
          r_code   <= r_code + STEP_V;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Complements come straight off the bit registers, so dNb == ~dN even in reset.
  assign mon_bus.sample  = r_sample;
  assign mon_bus.comp_en = r_comp_en;
  assign mon_bus.d1      = r_d[5];
  assign mon_bus.d2      = r_d[4];
  assign mon_bus.d3      = r_d[3];
  assign mon_bus.d4      = r_d[2];
  assign mon_bus.d5      = r_d[1];
  assign mon_bus.d6      = r_d[0];
  assign mon_bus.d1b     = ~r_d[5];
  assign mon_bus.d2b     = ~r_d[4];
  assign mon_bus.d3b     = ~r_d[3];
  assign mon_bus.d4b     = ~r_d[2];
  assign mon_bus.d5b     = ~r_d[1];
  assign mon_bus.d6b     = ~r_d[0];

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: four instances with different parameter sets
// share one clock and one randomly pulsed async reset. A frame-arithmetic
// reference model pushes expected outputs per cycle; a monitor pops and compares.
module tb_counter_monitor;

  localparam int NDUT   = 4;
  localparam int NCYC   = 900;
  localparam int SC_P   [NDUT] = '{2, 2, 4, 2};
  localparam int STEP_P [NDUT] = '{1, 1, 1, 5};
  localparam int INIT_P [NDUT] = '{0, 45, 63, 62};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] obs [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    counter_monitor_if u_if ();
    counter_monitor #(
      .SAMPLE_CYCLES(SC_P[g]),
      .CODE_STEP    (STEP_P[g]),
      .CODE_INIT    (INIT_P[g])
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mon_bus(u_if.master)
    );
    assign obs[g] = {u_if.sample, u_if.comp_en,
                     u_if.d1, u_if.d2, u_if.d3, u_if.d4, u_if.d5, u_if.d6,
                     u_if.d1b, u_if.d2b, u_if.d3b, u_if.d4b, u_if.d5b, u_if.d6b};
  end

  int errors = 0;
  int checks = 0;
  logic [14*NDUT-1:0] exp_q [$];

  // Expected {sample, comp_en, d1..d6, d1b..d6b} t clock edges after reset release.
  function automatic logic [13:0] model(int t, int sc, int init, int step);
    int flen, p, f, code, k, d, s, c;
    logic [5:0] dv;
    if (t == 0) return {2'b00, 6'b000000, 6'b111111};
    flen = sc + 7;
    p    = (t - 1) % flen;
    f    = (t - 1) / flen;
    code = (init + f * step) % 64;
    s = 0; c = 0; d = 0;
    if (p < sc) begin
      s = 1;
    end else if (p < sc + 6) begin
      k = p - sc;
      c = 1;
      d = code & ((63 >> (5 - k)) << (5 - k));
    end else begin
      d = code;
    end
    dv = 6'(d);
    return {1'(s), 1'(c), dv, ~dv};
  endfunction

  task automatic stimulus();
    int t = 0;
    int hold = 3;
    bit dir_done = 0;
    bit assert_now;
    logic [14*NDUT-1:0] e;
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      if (rst_n) t++; else t = 0;
      assert_now = 0;
      if (rst_n && !dir_done && i >= 120 && ((t - 1) % 9) == 4) begin
        assert_now = 1;
        dir_done = 1;
      end else if (rst_n && i > 400 && $urandom_range(0, 39) == 0) begin
        assert_now = 1;
      end
      if (assert_now) t = 0;
      for (int g = 0; g < NDUT; g++) e[14*g +: 14] = model(t, SC_P[g], INIT_P[g], STEP_P[g]);
      exp_q.push_back(e);
      if (assert_now) begin
        #2;
        rst_n = 1'b0;
        hold = $urandom_range(1, 3);
      end else if (!rst_n) begin
        hold--;
        if (hold == 0) begin
          #7;
          rst_n = 1'b1;
        end
      end
    end
  endtask

  task automatic monitor();
    logic [14*NDUT-1:0] e;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_underflow cycle %0d: no expected entry", i);
      end else begin
        e = exp_q.pop_front();
        for (int g = 0; g < NDUT; g++) begin
          checks++;
          if (obs[g] !== e[14*g +: 14]) begin
            errors++;
            $display("FAIL outputs dut%0d cycle %0d: got=%b expected=%b", g, i, obs[g], e[14*g +: 14]);
          end
          checks++;
          if (obs[g][13] && obs[g][12]) begin
            errors++;
            $display("FAIL exclusive dut%0d cycle %0d: sample=%b comp_en=%b required not both 1",
                     g, i, obs[g][13], obs[g][12]);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      stimulus();
      monitor();
    join
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
